// File: rtl/mips_pkg.sv
// Shared sequencer types: controller states and pipeline stage indices.
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } seq_state_e;

  localparam int STG_IF  = 0;
  localparam int STG_ID  = 1;
  localparam int STG_EX  = 2;
  localparam int STG_MEM = 3;
  localparam int STG_WB  = 4;

endpackage

// File: rtl/stage_sequencer_if.sv
// Control/status bundle between the stage sequencer and the pipeline it steps.
interface stage_sequencer_if #(
  parameter int NUM_STAGES = 5,
  parameter int PC_WIDTH   = 4,
  parameter int CNT_WIDTH  = 16
);
  logic                  go;
  logic [NUM_STAGES-1:0] stage_ready;
  logic [NUM_STAGES-1:0] skip_mask;
  logic                  branch_taken;
  logic [PC_WIDTH-1:0]   branch_target;
  logic                  end_program;
  logic [NUM_STAGES-1:0] stage;
  logic [PC_WIDTH-1:0]   pc;
  logic                  retire;
  logic                  halted;
  logic [CNT_WIDTH-1:0]  instr_count;

  modport master (
    output go, stage_ready, skip_mask, branch_taken, branch_target, end_program,
    input  stage, pc, retire, halted, instr_count
  );

  modport slave (
    input  go, stage_ready, skip_mask, branch_taken, branch_target, end_program,
    output stage, pc, retire, halted, instr_count
  );
endinterface

// File: rtl/stage_sequencer_next_stage_picker.sv
// Finds the lowest unskipped stage above the active one; none=1 means the
// active stage is the last one this instruction will visit.
module next_stage_picker #(
  parameter int NUM_STAGES = 5
) (
  input  logic [NUM_STAGES-1:0] active,
  input  logic [NUM_STAGES-1:0] skip,
  output logic [NUM_STAGES-1:0] succ,
  output logic                  none
);

  logic seen;

  always_comb begin
    succ = '0;
    none = 1'b1;
    seen = 1'b0;
    for (int j = 0; j < NUM_STAGES; j++) begin
      if (seen && !skip[j] && none) begin
        succ[j] = 1'b1;
        none    = 1'b0;
      end
      seen = seen | active[j];
    end
  end

endmodule

// File: rtl/stage_sequencer.sv
// Steps one instruction at a time through a one-hot stage chain, honouring
// per-instruction skip masks, and updates pc/count on retire.
//
// state | meaning
// IDLE  | waiting for go, no stage active
// RUN   | exactly one stage active, advancing on its stage_ready
// HALT  | program ended, only reset leaves
module stage_sequencer
  import mips_pkg::*;
#(
  parameter int NUM_STAGES = 5,
  parameter int DECODE_IDX = STG_ID,
  parameter int PC_WIDTH   = 4,
  parameter int CNT_WIDTH  = 16
) (
  input logic             clock,
  input logic             start_n,
  stage_sequencer_if.slave bus
);

  localparam logic [NUM_STAGES-1:0] FIRST_STAGE = NUM_STAGES'(1) << STG_IF;
  localparam logic [NUM_STAGES-1:0] ABOVE_DEC   = {NUM_STAGES{1'b1}} << (DECODE_IDX + 1);

  seq_state_e            state;
  logic [NUM_STAGES-1:0] stage_r;
  logic [NUM_STAGES-1:0] skip_lat;
  logic [NUM_STAGES-1:0] eff_skip;
  logic [NUM_STAGES-1:0] succ;
  logic                  succ_none;
  logic                  advance;
  logic [PC_WIDTH-1:0]   pc_r;
  logic                  retire_r;
  logic                  halted_r;
  logic [CNT_WIDTH-1:0]  count_r;

  // The decode stage's own completion uses the live mask; later stages use the latch.
  assign eff_skip = stage_r[DECODE_IDX] ? (bus.skip_mask & ABOVE_DEC) : skip_lat;
  assign advance  = |(stage_r & bus.stage_ready);

  next_stage_picker #(.NUM_STAGES(NUM_STAGES)) u_picker (
    .active (stage_r),
    .skip   (eff_skip),
    .succ   (succ),
    .none   (succ_none)
  );

  always_ff @(posedge clock or negedge start_n) begin
    if (!start_n) begin
      state    <= IDLE;
      stage_r  <= '0;
      skip_lat <= '0;
      pc_r     <= '0;
      retire_r <= 1'b0;
      halted_r <= 1'b0;
      count_r  <= '0;
    end else begin
      retire_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.go) begin
            state   <= RUN;
            stage_r <= FIRST_STAGE;
          end
        end
        RUN: begin
          if (advance) begin
            if (stage_r[DECODE_IDX]) skip_lat <= bus.skip_mask & ABOVE_DEC;
            if (!succ_none) begin
              stage_r <= succ;
            end else begin
              retire_r <= 1'b1;
              skip_lat <= '0;
              pc_r     <= bus.branch_taken ? bus.branch_target : pc_r + 1'b1;
              if (count_r != {CNT_WIDTH{1'b1}}) count_r <= count_r + 1'b1;
              if (bus.end_program) begin
                state    <= HALT;
                stage_r  <= '0;
                halted_r <= 1'b1;
              end else begin
                stage_r <= FIRST_STAGE;
              end
            end
          end
        end
        HALT: begin
          halted_r <= 1'b1;
        end
        default: begin
          state   <= IDLE;
          stage_r <= '0;
        end
      endcase
    end
  end

  assign bus.stage       = stage_r;
  assign bus.pc          = pc_r;
  assign bus.retire      = retire_r;
  assign bus.halted      = halted_r;
  assign bus.instr_count = count_r;

endmodule

// File: tb/tb_stage_sequencer.sv
// Directed bench: stimulus queues expected retire results, a monitor checks them.
module tb_stage_sequencer;

  typedef struct packed {
    logic [3:0]  pc;
    logic [15:0] cnt;
    logic        halted;
  } exp_t;

  logic clock;
  logic start_n;
  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sbq[$];

  stage_sequencer_if #(.NUM_STAGES(5), .PC_WIDTH(4), .CNT_WIDTH(16)) bus ();

  stage_sequencer #(
    .NUM_STAGES(5),
    .DECODE_IDX(1),
    .PC_WIDTH(4),
    .CNT_WIDTH(16)
  ) dut (
    .clock   (clock),
    .start_n (start_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  // Retire monitor: every retire pulse must match the oldest queued expectation.
  always @(negedge clock) begin
    if (start_n === 1'b1 && bus.retire === 1'b1) begin
      if (sbq.size() == 0) begin
        chk("unexpected_retire", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("retire_pc", bus.pc, e.pc);
        chk("retire_count", bus.instr_count, e.cnt);
        chk("retire_halted", bus.halted, e.halted);
      end
    end
  end

  // Runs one instruction whose first stage is already active. seq holds up to
  // five one-hot stage values (entry 0 in the low bits), n of them used.
  task automatic instr(input logic [4:0] skip, input logic bt, input logic [3:0] tgt,
                       input logic endp, input logic [24:0] seq, input int n,
                       input int stall_ex, input logic [3:0] exp_pc,
                       input logic [15:0] exp_cnt);
    logic [4:0] cur;
    for (int i = 0; i < n; i++) begin
      cur = seq[i*5 +: 5];
      chk($sformatf("stage_%0d", i), bus.stage, cur);
      bus.skip_mask   = (cur == 5'b00010) ? skip : ~skip;
      bus.stage_ready = 5'b11111;
      if (i == n - 1) begin
        bus.branch_taken  = bt;
        bus.branch_target = tgt;
        bus.end_program   = endp;
        sbq.push_back(exp_t'{pc: exp_pc, cnt: exp_cnt, halted: endp});
      end else begin
        bus.branch_taken  = 1'b1;
        bus.branch_target = ~tgt;
        bus.end_program   = 1'b1;
      end
      if (cur == 5'b00100 && stall_ex > 0) begin
        bus.stage_ready = 5'b11011;
        for (int s = 0; s < stall_ex; s++) begin
          tick();
          chk("stall_stage", bus.stage, 5'b00100);
        end
        bus.stage_ready = 5'b11111;
      end
      tick();
    end
    chk("post_retire_stage", bus.stage, endp ? 5'b00000 : 5'b00001);
    bus.branch_taken = 1'b0;
    bus.end_program  = 1'b0;
  endtask

  localparam logic [24:0] SEQ_FULL  = {5'b10000, 5'b01000, 5'b00100, 5'b00010, 5'b00001};
  localparam logic [24:0] SEQ_NOMEM = {5'b00000, 5'b10000, 5'b00100, 5'b00010, 5'b00001};
  localparam logic [24:0] SEQ_NOEX  = {5'b00000, 5'b10000, 5'b01000, 5'b00010, 5'b00001};
  localparam logic [24:0] SEQ_NOWB  = {5'b00000, 5'b01000, 5'b00100, 5'b00010, 5'b00001};
  localparam logic [24:0] SEQ_IFID  = {15'b0, 5'b00010, 5'b00001};

  initial begin
    start_n           = 1'b0;
    bus.go            = 1'b0;
    bus.stage_ready   = 5'b11111;
    bus.skip_mask     = 5'b00000;
    bus.branch_taken  = 1'b0;
    bus.branch_target = 4'h0;
    bus.end_program   = 1'b0;

    tick();
    tick();
    chk("rst_stage", bus.stage, 5'b00000);
    chk("rst_pc", bus.pc, 4'h0);
    chk("rst_count", bus.instr_count, 16'd0);
    chk("rst_halted", bus.halted, 1'b0);
    chk("rst_retire", bus.retire, 1'b0);

    start_n = 1'b1;
    tick();
    chk("idle_no_go", bus.stage, 5'b00000);
    bus.go = 1'b1;
    tick();

    // go stays high through the first instruction; RUN must ignore it
    instr(5'b00000, 1'b0, 4'h0, 1'b0, SEQ_FULL,  5, 0, 4'h1, 16'd1);
    bus.go = 1'b0;
    instr(5'b01000, 1'b0, 4'h0, 1'b0, SEQ_NOMEM, 4, 0, 4'h2, 16'd2);
    instr(5'b00011, 1'b0, 4'h0, 1'b0, SEQ_FULL,  5, 7, 4'h3, 16'd3);
    instr(5'b11100, 1'b1, 4'hF, 1'b0, SEQ_IFID,  2, 0, 4'hF, 16'd4);
    instr(5'b00000, 1'b0, 4'h0, 1'b0, SEQ_FULL,  5, 0, 4'h0, 16'd5);
    instr(5'b00100, 1'b1, 4'h9, 1'b0, SEQ_NOEX,  4, 0, 4'h9, 16'd6);
    instr(5'b10000, 1'b0, 4'h0, 1'b0, SEQ_NOWB,  4, 0, 4'hA, 16'd7);

    // abandon an instruction in MEM with an asynchronous reset pulse
    bus.skip_mask = 5'b00000;
    tick();
    tick();
    tick();
    chk("pre_reset_stage", bus.stage, 5'b01000);
    #2 start_n = 1'b0;
    #1;
    chk("async_rst_stage", bus.stage, 5'b00000);
    chk("async_rst_pc", bus.pc, 4'h0);
    chk("async_rst_count", bus.instr_count, 16'd0);
    chk("async_rst_retire", bus.retire, 1'b0);
    #1 start_n = 1'b1;
    tick();
    tick();
    chk("post_rst_idle", bus.stage, 5'b00000);
    chk("post_rst_pc", bus.pc, 4'h0);

    bus.go = 1'b1;
    tick();
    bus.go = 1'b0;
    instr(5'b00000, 1'b0, 4'h0, 1'b0, SEQ_FULL, 5, 0, 4'h1, 16'd1);
    instr(5'b00000, 1'b1, 4'h3, 1'b1, SEQ_FULL, 5, 0, 4'h3, 16'd2);

    bus.go = 1'b1;
    tick();
    tick();
    tick();
    chk("halt_stage", bus.stage, 5'b00000);
    chk("halt_flag", bus.halted, 1'b1);
    chk("halt_pc", bus.pc, 4'h3);
    chk("halt_count", bus.instr_count, 16'd2);
    chk("halt_retire", bus.retire, 1'b0);
    bus.go = 1'b0;

    tick();
    chk("pending_retires", sbq.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/stage_sequencer.md
STAGE_SEQUENCER -- requirements
Module: stage_sequencer

Interface
REQ-001 SHALL have parameter NUM_STAGES, default 5, number of processor stages (min 3).
REQ-002 SHALL have parameter DECODE_IDX, default 1, stage index at which skip_mask is sampled.
REQ-003 SHALL have parameter PC_WIDTH, default 4, program counter width.
REQ-004 SHALL have parameter CNT_WIDTH, default 16, retired-instruction counter width.
REQ-005 SHALL have port clock  in  1  sole clock, rising edge.
REQ-006 SHALL have port start_n  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have port go  in  1  begin execution from IDLE.
REQ-008 SHALL have port stage_ready  in  NUM_STAGES  per-stage completion, bit k meaningful only while stage k active.
REQ-009 SHALL have port skip_mask  in  NUM_STAGES  stages to bypass for the current instruction.
REQ-010 SHALL have port branch_taken  in  1  load branch_target at retire.
REQ-011 SHALL have port branch_target  in  PC_WIDTH  next pc when branch taken.
REQ-012 SHALL have port end_program  in  1  halt after the current instruction retires.
REQ-013 SHALL have port stage  out  NUM_STAGES  one-hot active stage; all-zero outside RUN.
REQ-014 SHALL have port pc  out  PC_WIDTH  address of the instruction in flight.
REQ-015 SHALL have port retire  out  1  one-cycle pulse per retired instruction.
REQ-016 SHALL have port halted  out  1  high in HALT.
REQ-017 SHALL have port instr_count  out  CNT_WIDTH  retired-instruction count.

Function
REQ-018 SHALL implement FSM states IDLE, RUN, HALT; IDLE->RUN on go; RUN->HALT at retire with end_program=1; HALT exits only by reset.
REQ-019 SHALL assert stage[0] in the cycle after the edge sampling go=1 in IDLE; go in RUN or HALT ignored.
REQ-020 SHALL hold the active stage while its stage_ready bit is 0 (unbounded stall); stage_ready bits of inactive stages ignored.
REQ-021 SHALL, on an edge where the active stage k has stage_ready[k]=1, move to the lowest index j>k whose effective skip bit is 0, one cycle later.
REQ-022 SHALL latch skip_mask at the completing edge of stage DECODE_IDX; latched bits apply only to stages after DECODE_IDX; bits at or below DECODE_IDX and the latch cleared at retire.
REQ-023 SHALL retire when the completing stage has no non-skipped successor (last stage or all remaining skipped): retire=1 for one cycle, next active stage = stage[0] unless halting.
REQ-024 SHALL at retire set pc to branch_target if branch_taken=1, else pc+1 modulo 2^PC_WIDTH (wrap, no flag).
REQ-025 SHALL on simultaneous end_program=1 and branch_taken=1 at retire load branch_target into pc and enter HALT.
REQ-026 SHALL increment instr_count at each retire, saturating at all-ones.
REQ-027 SHALL sample branch_taken, branch_target, end_program only at retire edge.
REQ-028 SHALL keep stage strictly one-hot in RUN; an all-skip mask yields retire directly from DECODE_IDX.

Reset
REQ-029 SHALL on start_n=0, immediately and regardless of clock: state=IDLE, stage=0, pc=0, retire=0, halted=0, instr_count=0, skip latch=0.
REQ-030 SHALL on reset mid-instruction abandon it without retire pulse or pc/count update; first post-reset edge with start_n=1 behaves as IDLE.

Structure
REQ-031 SHALL take the state enum (IDLE/RUN/HALT) and stage index constants (IF=0, ID=1, EX=2, MEM=3, WB=4) from shared package mips_pkg.
REQ-032 SHALL place next-stage selection (priority find of lowest unskipped index above k, plus "none" flag) in combinational sub-module next_stage_picker.

Verification
REQ-033 SHALL cover: reset, go=1, stage_ready all 1, skip_mask=0 -> stage 00001,00010,00100,01000,10000 on consecutive cycles, retire at cycle 5, pc 0->1, instr_count=1.
REQ-034 SHALL cover: skip_mask=5'b01000 latched at ID -> EX then WB, MEM never active, retire after 4 stage cycles.
REQ-035 SHALL cover: stage_ready[2] held 0 for 7 cycles -> stage stays 00100 for 8 cycles, no retire.
REQ-036 SHALL cover: pc=4'hF, no branch, retire -> pc=4'h0; branch_taken=1, branch_target=4'h9 -> pc=4'h9.
REQ-037 SHALL cover: end_program=1 and branch_taken=1 (target 4'h3) at retire -> halted=1, stage=0, pc=4'h3, go ignored.
REQ-038 SHALL cover: start_n pulsed low during MEM -> stage=0, pc=0, instr_count=0 asynchronously, no retire pulse.
